// File: rtl/exp4_unidade_controle.sv
// Control unit for one round of the exp3_fluxo_dados datapath.
// The round runs: clear, wait for a play, register it, compare it with the ROM,
// then advance or finish. A round also ends if no play arrives within
// TIMEOUT_CICLOS clocks.
// The unit is a Moore machine: every output depends only on the current state.
//
// Ports:
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   iniciar             level, starts a round from inicial or any fim_* state
//   fimC                address counter is at its last position
//   jogada_feita        1-cycle pulse, a new key press was detected
//   igual               ROM data equals the registered play
//   zeraC, contaC       clear / increment the address counter
//   zeraR, registraR    clear / load the play register
//   pronto              round finished (any fim_* state)
//   acertou, errou      round finished with all plays correct / a wrong play
//   timeout             round finished because no play arrived in time
//   db_estado           current state encoding, for debug display
module exp4_unidade_controle #(
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimC,
    input  logic       jogada_feita,
    input  logic       igual,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int unsigned TIMER_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'b0000,
        PREPARACAO    = 4'b0001,
        ESPERA_JOGADA = 4'b0010,
        REGISTRA      = 4'b0100,
        COMPARACAO    = 4'b0101,
        PROXIMO       = 4'b0110,
        FIM_ACERTOU   = 4'b1010,
        FIM_ERROU     = 4'b1110,
        FIM_TIMEOUT   = 4'b1101
    } estado_t;

    estado_t              state;
    estado_t              state_nxt;
    logic [TIMER_W-1:0]   timer;

    // Next-state decode; a play arriving on the last timer cycle takes priority.
    always_comb begin
        state_nxt = state;
        case (state)
            INICIAL:       if (iniciar) state_nxt = PREPARACAO;
            PREPARACAO:    state_nxt = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita)            state_nxt = REGISTRA;
                else if (timer == TIMER_MAX) state_nxt = FIM_TIMEOUT;
            end
            REGISTRA:      state_nxt = COMPARACAO;
            COMPARACAO: begin
                if (!igual)    state_nxt = FIM_ERROU;
                else if (fimC) state_nxt = FIM_ACERTOU;
                else           state_nxt = PROXIMO;
            end
            PROXIMO:       state_nxt = ESPERA_JOGADA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT:   if (iniciar) state_nxt = PREPARACAO;
            default:       state_nxt = INICIAL;
        endcase
    end

    // State, timer and outputs; outputs are decoded from the state being
    // entered so that they are registered yet still valid within that state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INICIAL;
            timer     <= '0;
            zeraC     <= 1'b0;
            contaC    <= 1'b0;
            zeraR     <= 1'b0;
            registraR <= 1'b0;
            pronto    <= 1'b0;
            acertou   <= 1'b0;
            errou     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nxt;

            // Timer only runs while staying in espera_jogada, so each entry starts at 0.
            if (state == ESPERA_JOGADA && state_nxt == ESPERA_JOGADA)
                timer <= timer + TIMER_W'(1);
            else
                timer <= '0;

            zeraC     <= 1'b0;
            contaC    <= 1'b0;
            zeraR     <= 1'b0;
            registraR <= 1'b0;
            pronto    <= 1'b0;
            acertou   <= 1'b0;
            errou     <= 1'b0;
            timeout   <= 1'b0;
            case (state_nxt)
                PREPARACAO: begin
                    zeraC <= 1'b1;
                    zeraR <= 1'b1;
                end
                REGISTRA:    registraR <= 1'b1;
                PROXIMO:     contaC    <= 1'b1;
                FIM_ACERTOU: begin
                    pronto  <= 1'b1;
                    acertou <= 1'b1;
                end
                FIM_ERROU: begin
                    pronto <= 1'b1;
                    errou  <= 1'b1;
                end
                FIM_TIMEOUT: begin
                    pronto  <= 1'b1;
                    timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign db_estado = state;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
module tb_exp4_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       fimC;
    logic       jogada_feita;
    logic       igual;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int n_pass = 0;
    int n_chk  = 0;
    int n_reg  = 0;
    int n_cnt  = 0;

    exp4_unidade_controle #(.TIMEOUT_CICLOS(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .fimC         (fimC),
        .jogada_feita (jogada_feita),
        .igual        (igual),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle.
    always @(negedge clock) begin
        if (registraR === 1'b1) n_reg++;
        if (contaC === 1'b1)    n_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Start a round from inicial or a fim_* state; ends at entry to espera_jogada.
    task automatic start_round();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
    endtask

    // One play from espera_jogada; a correct non-final play returns to espera_jogada.
    task automatic play(input logic ig, input logic fc);
        jogada_feita = 1'b1;
        step();
        jogada_feita = 1'b0;
        igual = ig;
        fimC  = fc;
        step();
        step();
        if (ig && !fc) step();
        igual = 1'b0;
        fimC  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0; fimC = 1'b0; jogada_feita = 1'b0; igual = 1'b0;
        step(); step();
        n_chk++;
        if (db_estado !== 4'b0000) $display("FAIL reset_state got=%b exp=0000", db_estado);
        else n_pass++;
        n_chk++;
        if ({zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} !== 8'h00)
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout});
        else n_pass++;
        reset = 1'b0;
        step();
        start_round();
        step();
        n_chk++;
        if (db_estado !== 4'b0010) $display("FAIL pre_reset_espera got=%b exp=0010", db_estado);
        else n_pass++;
        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (db_estado !== 4'b0000) $display("FAIL async_reset_state got=%b exp=0000", db_estado);
        else n_pass++;
        n_chk++;
        if ({zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} !== 8'h00)
            $display("FAIL async_reset_outputs got=%b exp=00000000",
                     {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout});
        else n_pass++;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_acerto();
        int r0, c0;
        r0 = n_reg; c0 = n_cnt;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        n_chk++;
        if ({db_estado, zeraC, zeraR} !== 6'b0001_11)
            $display("FAIL acerto_preparacao got=%b/%b%b exp=0001/11", db_estado, zeraC, zeraR);
        else n_pass++;
        step();
        for (int i = 0; i < 15; i++) begin
            play(1'b1, 1'b0);
            n_chk++;
            if (db_estado !== 4'b0010) $display("FAIL acerto_play%0d got=%b exp=0010", i, db_estado);
            else n_pass++;
        end
        play(1'b1, 1'b1);
        step();
        n_chk++;
        if (n_reg - r0 !== 16) $display("FAIL acerto_registraR got=%0d exp=16", n_reg - r0);
        else n_pass++;
        n_chk++;
        if (n_cnt - c0 !== 15) $display("FAIL acerto_contaC got=%0d exp=15", n_cnt - c0);
        else n_pass++;
        n_chk++;
        if ({db_estado, pronto, acertou, errou, timeout} !== 8'b1010_1100)
            $display("FAIL acerto_final got=%b %b%b%b%b exp=1010 1100",
                     db_estado, pronto, acertou, errou, timeout);
        else n_pass++;
    endtask

    task automatic test_erro();
        int r0, c0;
        r0 = n_reg; c0 = n_cnt;
        start_round();
        play(1'b1, 1'b0);
        play(1'b1, 1'b0);
        play(1'b0, 1'b0);
        n_chk++;
        if (n_reg - r0 !== 3) $display("FAIL erro_registraR got=%0d exp=3", n_reg - r0);
        else n_pass++;
        n_chk++;
        if (n_cnt - c0 !== 2) $display("FAIL erro_contaC got=%0d exp=2", n_cnt - c0);
        else n_pass++;
        n_chk++;
        if ({db_estado, pronto, acertou, errou, timeout} !== 8'b1110_1010)
            $display("FAIL erro_final got=%b %b%b%b%b exp=1110 1010",
                     db_estado, pronto, acertou, errou, timeout);
        else n_pass++;
    endtask

    task automatic test_restart();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        n_chk++;
        if ({db_estado, zeraC, zeraR, pronto, errou} !== 8'b0001_1100)
            $display("FAIL restart_preparacao got=%b %b%b%b%b exp=0001 1100",
                     db_estado, zeraC, zeraR, pronto, errou);
        else n_pass++;
        step();
        n_chk++;
        if ({db_estado, zeraC, zeraR} !== 6'b0010_00)
            $display("FAIL restart_espera got=%b %b%b exp=0010 00", db_estado, zeraC, zeraR);
        else n_pass++;
        n_chk++;
        if (dut.timer !== 3'd0) $display("FAIL restart_timer got=%0d exp=0", dut.timer);
        else n_pass++;
    endtask

    // Entered espera_jogada by the caller; the timeout lands 8 cycles later.
    task automatic test_timeout();
        for (int k = 1; k <= 7; k++) step();
        n_chk++;
        if ({db_estado, timeout} !== 5'b0010_0)
            $display("FAIL timeout_cycle7 got=%b %b exp=0010 0", db_estado, timeout);
        else n_pass++;
        step();
        n_chk++;
        if ({db_estado, pronto, timeout, errou, acertou} !== 8'b1101_1100)
            $display("FAIL timeout_cycle8 got=%b %b%b%b%b exp=1101 1100",
                     db_estado, pronto, timeout, errou, acertou);
        else n_pass++;
        // A play on the last allowed cycle wins over the timeout.
        start_round();
        for (int k = 1; k <= 7; k++) step();
        jogada_feita = 1'b1;
        step();
        jogada_feita = 1'b0;
        n_chk++;
        if ({db_estado, registraR, timeout} !== 6'b0100_10)
            $display("FAIL timeout_play_wins got=%b %b%b exp=0100 10", db_estado, registraR, timeout);
        else n_pass++;
        igual = 1'b0;
        step();
        step();
    endtask

    task automatic test_ignore();
        int r0;
        start_round();
        r0 = n_reg;
        jogada_feita = 1'b1;
        step();
        igual = 1'b1;
        step();
        step();
        jogada_feita = 1'b0;
        step();
        n_chk++;
        if (db_estado !== 4'b0010) $display("FAIL ignore_back_espera got=%b exp=0010", db_estado);
        else n_pass++;
        step();
        n_chk++;
        if (db_estado !== 4'b0010) $display("FAIL ignore_not_queued got=%b exp=0010", db_estado);
        else n_pass++;
        n_chk++;
        if (n_reg - r0 !== 1) $display("FAIL ignore_registraR got=%0d exp=1", n_reg - r0);
        else n_pass++;
        igual = 1'b0;
    endtask

    initial begin
        test_reset();
        test_acerto();
        test_erro();
        test_restart();
        test_timeout();
        test_ignore();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
